// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and sync/blank decodes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          enable,
  output logic          pix_en,
  output logic          hSync,
  output logic          vSync,
  output logic          bright,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] hCount_q, hCount_d;
  logic [CW-1:0] vCount_q, vCount_d;
  logic          hWrap, vWrap;

  // Gating with clear keeps the tick quiet during reset even when CLK_DIV=1.
  assign pix_en = enable & clear & (div_q == DIV_LAST);
  assign hWrap  = pix_en & (hCount_q == H_LAST);
  assign vWrap  = hWrap & (vCount_q == V_LAST);

  always_comb begin
    div_d    = div_q;
    hCount_d = hCount_q;
    vCount_d = vCount_q;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (pix_en) begin
      hCount_d = hWrap ? '0 : hCount_q + 1'b1;
    end
    if (hWrap) begin
      vCount_d = vWrap ? '0 : vCount_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      div_q    <= '0;
      hCount_q <= '0;
      vCount_q <= '0;
    end else begin
      div_q    <= div_d;
      hCount_q <= hCount_d;
      vCount_q <= vCount_d;
    end
  end

  assign hCount      = hCount_q;
  assign vCount      = vCount_q;
  assign hSync       = ((hCount_q >= HS_FIRST) && (hCount_q <= HS_LAST)) ? HS_POL : ~HS_POL;
  assign vSync       = ((vCount_q >= VS_FIRST) && (vCount_q <= VS_LAST)) ? VS_POL : ~VS_POL;
  assign bright      = enable & (hCount_q < H_ACT) & (vCount_q < V_ACT);
  assign vblank      = (vCount_q >= V_ACT);
  assign line_start  = pix_en & (hCount_q == '0);
  assign frame_start = line_start & (vCount_q == '0);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_q;
    if (vWrap) begin
      frame_d = frame_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_count = frame_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance (A) and a tiny
// active-high-sync, undivided instance (B) for vertical, wrap and frame checks.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;

  logic        clearA, enA, pixA, hsA, vsA, brA, lsA, fsA, vbA;
  logic [9:0]  hA, vA;
  logic [15:0] fcA;

  logic        clearB, enB, pixB, hsB, vsB, brB, lsB, fsB, vbB;
  logic [7:0]  hB, vB;
  logic [15:0] fcB;

  always #5 clk = ~clk;

  vga_timing_gen dutA (
    .clk(clk), .clear(clearA), .enable(enA), .pix_en(pixA),
    .hSync(hsA), .vSync(vsA), .bright(brA), .hCount(hA), .vCount(vA),
    .line_start(lsA), .frame_start(fsA), .vblank(vbA), .frame_count(fcA)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(8)
  ) dutB (
    .clk(clk), .clear(clearB), .enable(enB), .pix_en(pixB),
    .hSync(hsB), .vSync(vsB), .bright(brB), .hCount(hB), .vCount(vB),
    .line_start(lsB), .frame_start(fsB), .vblank(vbB), .frame_count(fcB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic advanceA(input int h, input int v, input string tag);
    int n = 0;
    while (!(hA == h && vA == v) && n < 5000) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(hA == h && vA == v), 1);
  endtask

  task automatic advanceB(input int h, input int v, input string tag);
    int n = 0;
    while (!(hB == h && vB == v) && n < 500) begin
      applyStimulus(1);
      n++;
    end
    checkOutput(tag, 32'(hB == h && vB == v), 1);
  endtask

  initial begin
    int n;
    clearA = 1'b0; enA = 1'b1;
    clearB = 1'b0; enB = 1'b1;
    #12;
    checkOutput("A_rst_h", hA, 0);
    checkOutput("A_rst_v", vA, 0);
    checkOutput("A_rst_pix", pixA, 0);
    checkOutput("A_rst_hs", hsA, 1);
    checkOutput("A_rst_vs", vsA, 1);
    checkOutput("A_rst_bright", brA, 1);
    checkOutput("A_rst_vblank", vbA, 0);
    checkOutput("A_rst_fc", fcA, 0);
    checkOutput("B_rst_pix", pixB, 0);
    checkOutput("B_rst_hs", hsB, 0);
    checkOutput("B_rst_vs", vsB, 0);
    checkOutput("B_rst_ls", lsB, 0);
    checkOutput("B_rst_fs", fsB, 0);
    checkOutput("B_rst_bright", brB, 1);

    clearA = 1'b1;
    checkOutput("A_rel_pix0", pixA, 0);
    checkOutput("A_rel_ls0", lsA, 0);
    applyStimulus(1);
    checkOutput("A_clk1_pix", pixA, 1);
    checkOutput("A_clk1_ls", lsA, 1);
    checkOutput("A_clk1_fs", fsA, 1);
    checkOutput("A_clk1_h", hA, 0);
    applyStimulus(1);
    checkOutput("A_clk2_pix", pixA, 0);
    checkOutput("A_clk2_h", hA, 1);
    checkOutput("A_clk2_fs", fsA, 0);
    applyStimulus(1);
    checkOutput("A_clk3_pix", pixA, 1);

    advanceA(639, 0, "A_reach639");
    checkOutput("A_bright639", brA, 1);
    advanceA(640, 0, "A_reach640");
    checkOutput("A_bright640", brA, 0);
    advanceA(655, 0, "A_reach655");
    checkOutput("A_hs655", hsA, 1);
    advanceA(656, 0, "A_reach656");
    checkOutput("A_hs656", hsA, 0);
    advanceA(751, 0, "A_reach751");
    checkOutput("A_hs751", hsA, 0);
    advanceA(752, 0, "A_reach752");
    checkOutput("A_hs752", hsA, 1);
    checkOutput("A_vs_line0", vsA, 1);
    checkOutput("A_vblank_line0", vbA, 0);

    advanceA(300, 1, "A_reach300");
    enA = 1'b0;
    applyStimulus(50);
    checkOutput("A_hold_h", hA, 300);
    checkOutput("A_hold_v", vA, 1);
    checkOutput("A_hold_bright", brA, 0);
    checkOutput("A_hold_pix", pixA, 0);
    checkOutput("A_hold_ls", lsA, 0);
    enA = 1'b1;
    applyStimulus(1);
    checkOutput("A_resume_pix", pixA, 1);
    checkOutput("A_resume_h300", hA, 300);
    applyStimulus(1);
    checkOutput("A_resume_h301", hA, 301);

    advanceA(700, 1, "A_reach700");
    clearA = 1'b0;
    #1;
    checkOutput("A_clr_h", hA, 0);
    checkOutput("A_clr_v", vA, 0);
    checkOutput("A_clr_hs", hsA, 1);
    checkOutput("A_clr_vs", vsA, 1);
    checkOutput("A_clr_pix", pixA, 0);
    checkOutput("A_clr_fc", fcA, 0);

    clearB = 1'b1;
    #1;
    checkOutput("B_rel_pix", pixB, 1);
    checkOutput("B_rel_fs", fsB, 1);
    n = 0;
    do begin
      applyStimulus(1);
      n++;
    end while (!lsB && n < 100);
    checkOutput("B_line_period", n, 14);
    checkOutput("B_line_v", vB, 1);

    advanceB(9, 1, "B_reach9");
    checkOutput("B_hs9", hsB, 0);
    advanceB(10, 1, "B_reach10");
    checkOutput("B_hs10", hsB, 1);
    advanceB(11, 1, "B_reach11");
    checkOutput("B_hs11", hsB, 1);
    advanceB(12, 1, "B_reach12");
    checkOutput("B_hs12", hsB, 0);

    advanceB(7, 3, "B_reach7_3");
    checkOutput("B_bright7_3", brB, 1);
    checkOutput("B_vblank3", vbB, 0);
    advanceB(8, 3, "B_reach8_3");
    checkOutput("B_bright8_3", brB, 0);
    advanceB(0, 4, "B_reach0_4");
    checkOutput("B_vblank4", vbB, 1);
    checkOutput("B_bright0_4", brB, 0);
    checkOutput("B_vs4", vsB, 0);
    advanceB(0, 5, "B_reach0_5");
    checkOutput("B_vs5", vsB, 1);
    advanceB(0, 6, "B_reach0_6");
    checkOutput("B_vs6", vsB, 0);

    advanceB(13, 6, "B_reach13_6");
    checkOutput("B_fc_before", fcB, 0);
    checkOutput("B_fs_before", fsB, 0);
    applyStimulus(1);
    checkOutput("B_wrap_h", hB, 0);
    checkOutput("B_wrap_v", vB, 0);
    checkOutput("B_wrap_fs", fsB, 1);
    checkOutput("B_wrap_fc", fcB, FC_EN ? 1 : 0);
    applyStimulus(1);
    checkOutput("B_fs_width", fsB, 0);
    n = 1;
    while (!fsB && n < 200) begin
      applyStimulus(1);
      n++;
    end
    checkOutput("B_frame_period", n, 98);
    checkOutput("B_fc_second", fcB, FC_EN ? 2 : 0);

    enB = 1'b0;
    #1;
    checkOutput("B_dis_pix", pixB, 0);
    checkOutput("B_dis_ls", lsB, 0);
    checkOutput("B_dis_fs", fsB, 0);
    checkOutput("B_dis_bright", brB, 0);
    applyStimulus(5);
    checkOutput("B_dis_hold_h", hB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
